// File: rtl/mm_pin_host.sv
// rtl/mm_pin_host.sv - pin-level host sequencer for the 2x2 matrix-multiply macro
module mm_pin_host #(
    parameter int RESET_TARGET = 1,
    parameter int RST_CYCLES   = 2,
    parameter int HOLD_CYCLES  = 2,
    parameter int EXEC_CYCLES  = 1,
    parameter int COMPUTE_WAIT = 4,
    parameter int SETTLE       = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] mat_a,
    input  logic [31:0] mat_b,
    output logic        busy,
    output logic        mm_reset,
    output logic        mm_execute,
    output logic [7:0]  mm_input_val,
    output logic [2:0]  mm_sel_in,
    output logic [1:0]  mm_sel_out,
    input  logic [16:0] mm_out,
    output logic [67:0] result,
    output logic        result_valid,
    input  logic        result_ready,
    output logic [3:0]  mismatch,
    output logic        error
);

    localparam int CW = 16;
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RST  = 3'd1;
    localparam logic [2:0] S_LOAD = 3'd2;
    localparam logic [2:0] S_EXEC = 3'd3;
    localparam logic [2:0] S_WAIT = 3'd4;
    localparam logic [2:0] S_READ = 3'd5;
    localparam logic [2:0] S_DONE = 3'd6;

    logic [2:0]       state, nstate;
    logic [CW-1:0]    cnt, ncnt;
    logic [2:0]       idx, nidx;
    logic [31:0]      a_q, b_q;
    logic [63:0]      ops;
    logic [3:0][16:0] golden;
    logic [3:0][16:0] res_q;
    logic [3:0]       nmis;
    logic             sample;
    logic             load_pins;

    function automatic logic [16:0] dot(input logic [7:0] x0, input logic [7:0] y0,
                                        input logic [7:0] x1, input logic [7:0] y1);
        return {9'd0, x0} * {9'd0, y0} + {9'd0, x1} * {9'd0, y1};
    endfunction

    // Operand slot k of the macro is byte k of {B, A}
    assign ops = {b_q, a_q};
    assign result = res_q;

    always_comb begin
        golden[0] = dot(a_q[7:0],   b_q[7:0],  a_q[15:8],  b_q[23:16]);
        golden[1] = dot(a_q[7:0],   b_q[15:8], a_q[15:8],  b_q[31:24]);
        golden[2] = dot(a_q[23:16], b_q[7:0],  a_q[31:24], b_q[23:16]);
        golden[3] = dot(a_q[23:16], b_q[15:8], a_q[31:24], b_q[31:24]);
    end

    assign sample = (state == S_READ) && (cnt == CW'(SETTLE - 1));

    always_comb begin
        nmis = mismatch;
        if (state == S_IDLE && start)
            nmis = 4'd0;
        if (sample)
            nmis[idx[1:0]] = (mm_out != golden[idx[1:0]]);
    end

    always_comb begin
        nstate = state;
        ncnt   = cnt + CW'(1);
        nidx   = idx;
        case (state)
            S_IDLE: begin
                ncnt = '0;
                nidx = '0;
                if (start)
                    nstate = (RESET_TARGET != 0) ? S_RST : S_LOAD;
            end
            S_RST: begin
                if (cnt == CW'(RST_CYCLES - 1)) begin
                    nstate = S_LOAD;
                    ncnt   = '0;
                end
            end
            S_LOAD: begin
                if (cnt == CW'(HOLD_CYCLES - 1)) begin
                    ncnt = '0;
                    if (idx == 3'd7)
                        nstate = S_EXEC;
                    else
                        nidx = idx + 3'd1;
                end
            end
            S_EXEC: begin
                if (cnt == CW'(EXEC_CYCLES - 1)) begin
                    nstate = (COMPUTE_WAIT == 0) ? S_READ : S_WAIT;
                    ncnt   = '0;
                    nidx   = '0;
                end
            end
            S_WAIT: begin
                if (cnt == CW'(COMPUTE_WAIT - 1)) begin
                    nstate = S_READ;
                    ncnt   = '0;
                end
            end
            S_READ: begin
                if (sample) begin
                    ncnt = '0;
                    if (idx == 3'd3)
                        nstate = S_DONE;
                    else
                        nidx = idx + 3'd1;
                end
            end
            S_DONE: begin
                ncnt = '0;
                if (result_ready)
                    nstate = S_IDLE;
            end
            default: begin
                nstate = S_IDLE;
                ncnt   = '0;
                nidx   = '0;
            end
        endcase
    end

    // Pins are registered from the next state so they line up with the state they belong to
    assign load_pins = (nstate == S_LOAD) || (nstate == S_EXEC);

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            cnt          <= '0;
            idx          <= '0;
            a_q          <= '0;
            b_q          <= '0;
            busy         <= 1'b0;
            mm_reset     <= 1'b1;
            mm_execute   <= 1'b0;
            mm_input_val <= '0;
            mm_sel_in    <= '0;
            mm_sel_out   <= '0;
            res_q        <= '0;
            result_valid <= 1'b0;
            mismatch     <= '0;
            error        <= 1'b0;
        end else begin
            state <= nstate;
            cnt   <= ncnt;
            idx   <= nidx;
            if (state == S_IDLE && start) begin
                a_q   <= mat_a;
                b_q   <= mat_b;
                res_q <= '0;
            end
            if (sample)
                res_q[idx[1:0]] <= mm_out;
            mismatch     <= nmis;
            error        <= |nmis;
            busy         <= (nstate != S_IDLE) && (nstate != S_DONE);
            mm_reset     <= (nstate == S_RST);
            mm_execute   <= (nstate == S_EXEC);
            mm_sel_in    <= load_pins ? nidx : 3'd0;
            mm_input_val <= load_pins ? ops[{nidx, 3'b000} +: 8] : 8'd0;
            mm_sel_out   <= (nstate == S_READ) ? nidx[1:0] : 2'd0;
            result_valid <= (nstate == S_DONE);
        end
    end

endmodule

// File: tb/tb_mm_pin_host.sv
// tb/tb_mm_pin_host.sv - directed bench for mm_pin_host with a behavioural macro model
module tb_mm_pin_host;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] mat_a, mat_b;
    logic        busy, mm_reset, mm_execute;
    logic [7:0]  mm_input_val;
    logic [2:0]  mm_sel_in;
    logic [1:0]  mm_sel_out;
    logic [16:0] mm_out;
    logic [67:0] result;
    logic        result_valid, result_ready;
    logic [3:0]  mismatch;
    logic        error;
    logic        fault;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mm_pin_host dut (
        .clk(clk), .reset(reset), .start(start), .mat_a(mat_a), .mat_b(mat_b),
        .busy(busy), .mm_reset(mm_reset), .mm_execute(mm_execute),
        .mm_input_val(mm_input_val), .mm_sel_in(mm_sel_in), .mm_sel_out(mm_sel_out),
        .mm_out(mm_out), .result(result), .result_valid(result_valid),
        .result_ready(result_ready), .mismatch(mismatch), .error(error)
    );

    // Target macro: latches operand slots, multiplies on execute, optional C10 fault
    logic [7:0]  tmem [8];
    logic [16:0] tprod [4];

    always @(posedge clk) begin
        if (mm_reset) begin
            for (int i = 0; i < 8; i++) tmem[i] <= 8'd0;
            for (int i = 0; i < 4; i++) tprod[i] <= 17'd0;
        end else begin
            tmem[mm_sel_in] <= mm_input_val;
            if (mm_execute) begin
                tprod[0] <= {9'd0, tmem[0]} * {9'd0, tmem[4]} + {9'd0, tmem[1]} * {9'd0, tmem[6]};
                tprod[1] <= {9'd0, tmem[0]} * {9'd0, tmem[5]} + {9'd0, tmem[1]} * {9'd0, tmem[7]};
                tprod[2] <= {9'd0, tmem[2]} * {9'd0, tmem[4]} + {9'd0, tmem[3]} * {9'd0, tmem[6]};
                tprod[3] <= {9'd0, tmem[2]} * {9'd0, tmem[5]} + {9'd0, tmem[3]} * {9'd0, tmem[7]};
            end
        end
    end

    assign mm_out = tprod[mm_sel_out] + ((fault && mm_sel_out == 2'd2) ? 17'd1 : 17'd0);

    task automatic check(input string tag, input logic [67:0] got, input logic [67:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_idle_pins(input string tag);
        check({tag, ".busy"}, 68'(busy), 68'd0);
        check({tag, ".exec"}, 68'(mm_execute), 68'd0);
        check({tag, ".sel_in"}, 68'(mm_sel_in), 68'd0);
        check({tag, ".val"}, 68'(mm_input_val), 68'd0);
        check({tag, ".sel_out"}, 68'(mm_sel_out), 68'd0);
        check({tag, ".valid"}, 68'(result_valid), 68'd0);
        check({tag, ".mis"}, 68'(mismatch), 68'd0);
        check({tag, ".err"}, 68'(error), 68'd0);
    endtask

    // Called at a falling edge in IDLE; returns at the falling edge after release
    task automatic run_job(input logic [31:0] a, input logic [31:0] b,
                           input logic [67:0] exp_res, input logic [3:0] exp_mis,
                           input int hold);
        logic [63:0] ops;
        int exp_si, exp_v, exp_so;
        ops   = {b, a};
        mat_a = a;
        mat_b = b;
        start = 1'b1;
        for (int n = 1; n <= 32; n++) begin
            @(negedge clk);
            if (n == 1) start = 1'b0;
            exp_si = (n >= 3 && n <= 18) ? (n - 3) / 2 : ((n == 19) ? 7 : 0);
            exp_v  = (n >= 3 && n <= 19) ? int'(ops[exp_si*8 +: 8]) : 0;
            exp_so = (n >= 24 && n <= 31) ? (n - 24) / 2 : 0;
            check($sformatf("busy@T+%0d", n), 68'(busy), 68'(n <= 31));
            check($sformatf("mm_reset@T+%0d", n), 68'(mm_reset), 68'(n <= 2));
            check($sformatf("exec@T+%0d", n), 68'(mm_execute), 68'(n == 19));
            check($sformatf("sel_in@T+%0d", n), 68'(mm_sel_in), 68'(exp_si));
            check($sformatf("val@T+%0d", n), 68'(mm_input_val), 68'(exp_v));
            check($sformatf("sel_out@T+%0d", n), 68'(mm_sel_out), 68'(exp_so));
            check($sformatf("valid@T+%0d", n), 68'(result_valid), 68'(n == 32));
        end
        check("result", result, exp_res);
        check("mismatch", 68'(mismatch), 68'(exp_mis));
        check("error", 68'(error), 68'(exp_mis != 4'd0));
        for (int h = 1; h <= hold; h++) begin
            if (h == 3) start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            check("hold.valid", 68'(result_valid), 68'd1);
            check("hold.busy", 68'(busy), 68'd0);
            check("hold.result", result, exp_res);
            check("hold.mis", 68'(mismatch), 68'(exp_mis));
        end
        result_ready = 1'b1;
        @(negedge clk);
        result_ready = 1'b0;
        check("release.valid", 68'(result_valid), 68'd0);
        check("release.busy", 68'(busy), 68'd0);
        check("release.mm_reset", 68'(mm_reset), 68'd0);
    endtask

    localparam logic [31:0] A1 = {8'd4, 8'd3, 8'd2, 8'd1};
    localparam logic [31:0] B1 = {8'd8, 8'd7, 8'd6, 8'd5};
    localparam logic [67:0] R1 = {17'd50, 17'd43, 17'd22, 17'd19};
    localparam logic [67:0] R1F = {17'd50, 17'd44, 17'd22, 17'd19};
    localparam logic [67:0] RMAX = {17'h1FC02, 17'h1FC02, 17'h1FC02, 17'h1FC02};
    localparam logic [31:0] A2 = {8'd40, 8'd30, 8'd20, 8'd10};
    localparam logic [31:0] B2 = {8'd5, 8'd4, 8'd3, 8'd2};
    localparam logic [67:0] R2 = {17'd290, 17'd220, 17'd130, 17'd100};

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        start = 1'b0;
        result_ready = 1'b0;
        fault = 1'b0;
        mat_a = '0;
        mat_b = '0;
        repeat (3) @(negedge clk);
        check_idle_pins("reset");
        check("reset.mm_reset", 68'(mm_reset), 68'd1);
        check("reset.result", result, 68'd0);
        reset = 1'b0;
        @(negedge clk);
        check("post_reset.mm_reset", 68'(mm_reset), 68'd0);
        check_idle_pins("post_reset");

        run_job(A1, B1, R1, 4'b0000, 0);
        run_job(32'hFFFF_FFFF, 32'hFFFF_FFFF, RMAX, 4'b0000, 0);
        fault = 1'b1;
        run_job(A1, B1, R1F, 4'b0100, 0);
        fault = 1'b0;
        run_job(A2, B2, R2, 4'b0000, 10);
        run_job(A1, B1, R1, 4'b0000, 0);

        // Abort during LOAD
        mat_a = A2;
        mat_b = B2;
        start = 1'b1;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            if (n == 1) start = 1'b0;
        end
        check("mid.busy_before", 68'(busy), 68'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_idle_pins("abort");
        check("abort.mm_reset", 68'(mm_reset), 68'd1);
        check("abort.result", result, 68'd0);
        @(negedge clk);
        check("abort.after.mm_reset", 68'(mm_reset), 68'd0);
        check_idle_pins("abort.after");
        run_job(A1, B1, R1, 4'b0000, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mm_pin_host.md
Name: mm_pin_host

Overview:
- Host-side sequencer that drives the pin-level protocol of the 2x2 matrix-multiply macro: load operands, trigger, read back.
- Loads eight 8-bit operand bytes through the input_val/sel_in pins and pulses execute.
- Reads the four 17-bit products back by stepping sel_out and sampling the out pins.
- Computes a golden product internally and flags mismatches. Used as an on-FPGA/board-side test driver and as a reusable bench master.

Parameters:
- RESET_TARGET, 1: 1 = pulse mm_reset before each job; 0 = skip.
- RST_CYCLES, 2: cycles mm_reset held high per job (only when RESET_TARGET=1).
- HOLD_CYCLES, 2: cycles each operand byte/sel_in pair is held (>=1).
- EXEC_CYCLES, 1: cycles mm_execute is held high (>=1).
- COMPUTE_WAIT, 4: idle cycles between execute deassertion and the first readback (>=0).
- SETTLE, 2: cycles each sel_out value is held; out is sampled in the last cycle (>=1).

Ports:
- clk  in  1  single clock, also the target macro clock.
- reset  in  1  synchronous, active-high.
- start  in  1  job request, sampled only in IDLE.
- mat_a  in  32  A00[7:0], A01[15:8], A10[23:16], A11[31:24], unsigned.
- mat_b  in  32  B00, B01, B10, B11, same packing as mat_a.
- busy  out  1  job in progress.
- mm_reset  out  1  drives the target reset pin.
- mm_execute  out  1  drives the target execute pin.
- mm_input_val  out  8  drives the target input_val pins.
- mm_sel_in  out  3  operand slot: 0-3 = A00..A11, 4-7 = B00..B11.
- mm_sel_out  out  2  result select: 0 = C00, 1 = C01, 2 = C10, 3 = C11.
- mm_out  in  17  target result pins.
- result  out  68  {C11,C10,C01,C00}, 17 bits each.
- result_valid  out  1  result held, awaiting result_ready.
- result_ready  in  1  consumer accepts the result.
- mismatch  out  4  bit j set = sampled result j differs from the golden value.
- error  out  1  OR of mismatch; meaningful while result_valid is high.

Behaviour:
- All outputs are registered. Reset takes effect on the clock edge where reset=1.
- Reset values: state IDLE; busy 0; mm_reset 1 (deasserts on the first cycle after reset drops); mm_execute 0; mm_input_val 0; mm_sel_in 0; mm_sel_out 0; result 0; result_valid 0; mismatch 0; error 0.
- Reset mid-job aborts immediately with no partial result. The next start runs a full job.
- States: IDLE -> RST_T -> LOAD -> EXEC -> WAIT -> READ -> DONE -> IDLE.
- IDLE: start=1 in cycle T captures mat_a and mat_b, sets busy from T+1, and moves to RST_T (or to LOAD if RESET_TARGET=0). Pin outputs sit at their reset values, except mm_reset=0.
- RST_T: mm_reset=1 for RST_CYCLES cycles.
- LOAD: for k = 0..7, drive mm_sel_in=k and mm_input_val=operand byte k, each for HOLD_CYCLES cycles.
- EXEC: mm_execute=1 for EXEC_CYCLES cycles. mm_sel_in and mm_input_val hold the k=7 values.
- WAIT: COMPUTE_WAIT cycles with all pins quiet (execute=0).
- READ: for j = 0..3, drive mm_sel_out=j for SETTLE cycles. On the last cycle of each window, latch mm_out into result[j] and set mismatch[j] = (mm_out != golden[j]).
- DONE: result_valid=1, busy=0. result, mismatch and error stay stable until result_valid && result_ready; IDLE follows on the next cycle.
- start is ignored in every state except IDLE, including while result_valid is pending.
- Golden value: Cij = Ai0*Bj-column = Ai0*B0j + Ai1*B1j, unsigned, 17 bits, computed from the captured operands. Maximum 255*255*2 = 130050, so no overflow.
- Default timing, start at T:
  - T+1..T+2 RST_T
  - T+3..T+18 LOAD
  - T+19 EXEC
  - T+20..T+23 WAIT
  - T+24..T+31 READ
  - T+32 result_valid=1
- With RESET_TARGET=0, result_valid rises at T+30.

Test Plan:
- A=[[1,2],[3,4]], B=[[5,6],[7,8]], correct target model, start at T -> result C00=19, C01=22, C10=43, C11=50; result_valid at T+32; mismatch=0, error=0.
- All operand bytes 255 -> every Cij=130050 (0x1FC02); error=0.
- Target model returns C10+1 -> result[2]=44; mismatch=4'b0100; error=1.
- result_ready held low 10 cycles with start pulsed meanwhile -> result stable, no new job; ready=1 -> IDLE next cycle; a following start is accepted normally.
- reset at T+10 (mid LOAD) -> next cycle all outputs at reset values, busy=0; a subsequent start produces correct results.
- Pin monitor on the default job -> mm_sel_in steps 0..7, 2 cycles each with matching byte; mm_execute high exactly 1 cycle; mm_sel_out steps 0..3, 2 cycles each.
